// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, register-file addressing and write-port grant encoding for wb_ctrl
package wb_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
  typedef enum logic [1:0] {GNT_NONE, GNT_MDU, GNT_EX} gnt_e;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register busy bits for outstanding MDU results plus RAW/WAW lookups
module wb_scoreboard import wb_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_set,
  input  logic [REG_AW-1:0] i_set_addr,
  input  logic              i_clr,
  input  logic [REG_AW-1:0] i_clr_addr,
  input  logic [REG_AW-1:0] i_rs1,
  input  logic [REG_AW-1:0] i_rs2,
  input  logic [REG_AW-1:0] i_ex_addr,
  output logic              o_rs1_busy,
  output logic              o_rs2_busy,
  output logic              o_ex_busy,
  output logic              o_any_busy
);
  logic [NREG-1:0] r_busy, w_set, w_clr;
  always_comb begin
    w_set = '0;
    w_clr = '0;
    w_set[i_set_addr] = i_set && i_set_addr != REG_ZERO;
    w_clr[i_clr_addr] = i_clr;
  end
  // set is applied after clear so a re-issue in the drain cycle keeps the bit
  always_ff @(posedge clk)
    r_busy <= !rst ? '0 : ((r_busy & ~w_clr) | w_set) & ~NREG'(1);
  assign o_rs1_busy = r_busy[i_rs1];
  assign o_rs2_busy = r_busy[i_rs2];
  assign o_ex_busy  = r_busy[i_ex_addr];
  assign o_any_busy = |r_busy;
endmodule

// File: rtl/wb_ctrl.sv
// wb_ctrl: register-file write-port arbiter between EX and a 1-entry MDU result buffer.
// Define WB_PERF_EN to add saturating EX-stall / ID-hazard cycle counters.
module wb_ctrl import wb_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_wen_i,
  input  logic [REG_AW-1:0] ex_waddr_i,
  input  logic [XLEN-1:0]   ex_wdata_i,
  output logic              ex_stall_o,
  input  logic              mdu_issue_i,
  input  logic [REG_AW-1:0] mdu_issue_rd_i,
  input  logic              mdu_valid_i,
  input  logic [REG_AW-1:0] mdu_waddr_i,
  input  logic [XLEN-1:0]   mdu_wdata_i,
  output logic              mdu_ready_o,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  output logic              id_hazard_o,
  output logic              reg_wen_o,
  output logic [REG_AW-1:0] reg_waddr_o,
  output logic [XLEN-1:0]   reg_wdata_o
`ifdef WB_PERF_EN
  ,
  output logic [31:0]       ex_stall_cnt_o,
  output logic [31:0]       id_hazard_cnt_o
`endif
);
  logic              r_buf_full;
  logic [REG_AW-1:0] r_buf_addr;
  logic [XLEN-1:0]   r_buf_data;
  logic              w_ex_busy, w_rs1_busy, w_rs2_busy, w_any_busy, w_ex_stall;
  gnt_e              w_gnt;
  wb_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_set      (mdu_issue_i),
    .i_set_addr (mdu_issue_rd_i),
    .i_clr      (r_buf_full),
    .i_clr_addr (r_buf_addr),
    .i_rs1      (id_rs1_i),
    .i_rs2      (id_rs2_i),
    .i_ex_addr  (ex_waddr_i),
    .o_rs1_busy (w_rs1_busy),
    .o_rs2_busy (w_rs2_busy),
    .o_ex_busy  (w_ex_busy),
    .o_any_busy (w_any_busy)
  );
  // busy[ex_waddr] stalls EX so a pending older MDU write cannot land on top of it
  assign w_ex_stall = ex_wen_i && (r_buf_full || w_ex_busy);
  assign w_gnt = r_buf_full ? GNT_MDU : (ex_wen_i && !w_ex_stall) ? GNT_EX : GNT_NONE;
  always_ff @(posedge clk)
    if (!rst) r_buf_full <= 1'b0;
    else r_buf_full <= mdu_valid_i && !r_buf_full;
  always_ff @(posedge clk)
    if (mdu_valid_i && !r_buf_full) begin
      r_buf_addr <= mdu_waddr_i;
      r_buf_data <= mdu_wdata_i;
    end
  always_comb begin
    reg_wen_o   = rst && w_gnt != GNT_NONE;
    reg_waddr_o = !rst ? REG_ZERO : w_gnt == GNT_MDU ? r_buf_addr : w_gnt == GNT_EX ? ex_waddr_i : REG_ZERO;
    reg_wdata_o = !rst ? '0 : w_gnt == GNT_MDU ? r_buf_data : w_gnt == GNT_EX ? ex_wdata_i : '0;
    ex_stall_o  = rst && w_ex_stall;
    id_hazard_o = rst && (w_rs1_busy || w_rs2_busy);
    mdu_ready_o = rst && !r_buf_full;
  end
`ifdef WB_PERF_EN
  always_ff @(posedge clk)
    if (!rst) begin
      ex_stall_cnt_o  <= '0;
      id_hazard_cnt_o <= '0;
    end else begin
      if (ex_stall_o && ~&ex_stall_cnt_o) ex_stall_cnt_o <= ex_stall_cnt_o + 32'd1;
      if (id_hazard_o && ~&id_hazard_cnt_o) id_hazard_cnt_o <= id_hazard_cnt_o + 32'd1;
    end
`endif
  // one MDU op in flight; a new issue is legal once the previous result sits in the buffer
  a_one_mdu: assert property (@(posedge clk) disable iff (!rst) mdu_issue_i |-> (!w_any_busy || r_buf_full));
endmodule

// File: tb/tb_wb_ctrl.sv
// tb_wb_ctrl: directed self-checking bench for wb_ctrl
module tb_wb_ctrl;
  import wb_pkg::*;
  logic              clk, rst;
  logic              ex_wen_i, ex_stall_o, mdu_issue_i, mdu_valid_i, mdu_ready_o, id_hazard_o, reg_wen_o;
  logic [REG_AW-1:0] ex_waddr_i, mdu_issue_rd_i, mdu_waddr_i, id_rs1_i, id_rs2_i, reg_waddr_o;
  logic [XLEN-1:0]   ex_wdata_i, mdu_wdata_i, reg_wdata_o;
  logic [REG_AW-1:0] pend_rd;
  int n_chk = 0;
  int n_fail = 0;
  wb_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .ex_wen_i       (ex_wen_i),
    .ex_waddr_i     (ex_waddr_i),
    .ex_wdata_i     (ex_wdata_i),
    .ex_stall_o     (ex_stall_o),
    .mdu_issue_i    (mdu_issue_i),
    .mdu_issue_rd_i (mdu_issue_rd_i),
    .mdu_valid_i    (mdu_valid_i),
    .mdu_waddr_i    (mdu_waddr_i),
    .mdu_wdata_i    (mdu_wdata_i),
    .mdu_ready_o    (mdu_ready_o),
    .id_rs1_i       (id_rs1_i),
    .id_rs2_i       (id_rs2_i),
    .id_hazard_o    (id_hazard_o),
    .reg_wen_o      (reg_wen_o),
    .reg_waddr_o    (reg_waddr_o),
    .reg_wdata_o    (reg_wdata_o)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic port(input string tag, input logic wen, input logic [REG_AW-1:0] a, input logic [XLEN-1:0] d, input logic stall);
    chk({tag, ".wen"}, 32'(reg_wen_o), 32'(wen));
    chk({tag, ".waddr"}, 32'(reg_waddr_o), 32'(a));
    chk({tag, ".wdata"}, reg_wdata_o, d);
    chk({tag, ".stall"}, 32'(ex_stall_o), 32'(stall));
  endtask
  task automatic issue(input logic [REG_AW-1:0] rd);
    mdu_issue_i = 1'b1;
    mdu_issue_rd_i = rd;
    if (rd != 0) pend_rd = rd;
  endtask
  task automatic deliver(input logic [REG_AW-1:0] a, input logic [XLEN-1:0] d);
    if (a == 0 || a != pend_rd) $error("protocol violation: MDU result to non-busy x%0d", a);
    mdu_valid_i = 1'b1;
    mdu_waddr_i = a;
    mdu_wdata_i = d;
  endtask
  initial begin
    pend_rd = '0;
    rst = 1'b0;
    ex_wen_i = 1'b1; ex_waddr_i = 5'd5; ex_wdata_i = 32'hAA;
    mdu_issue_i = 1'b1; mdu_issue_rd_i = 5'd6;
    mdu_valid_i = 1'b0; mdu_waddr_i = '0; mdu_wdata_i = '0;
    id_rs1_i = 5'd6; id_rs2_i = 5'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      port("rst", 0, 0, 0, 0);
      chk("rst.ready", 32'(mdu_ready_o), 0);
      chk("rst.hazard", 32'(id_hazard_o), 0);
      cyc;
    end
    rst = 1'b1; ex_wen_i = 1'b0; mdu_issue_i = 1'b0;
    @(negedge clk);
    chk("post_rst.hazard", 32'(id_hazard_o), 0);
    chk("post_rst.ready", 32'(mdu_ready_o), 1);
    port("post_rst", 0, 0, 0, 0);
    cyc;
    ex_wen_i = 1'b1; ex_waddr_i = 5'd5; ex_wdata_i = 32'h1234;
    @(negedge clk);
    port("ex_only", 1, 5, 32'h1234, 0);
    cyc;
    ex_wen_i = 1'b0; issue(5'd7); id_rs1_i = 5'd7;
    @(negedge clk);
    chk("issue7.hazard_same_cycle", 32'(id_hazard_o), 0);
    cyc;
    mdu_issue_i = 1'b0;
    @(negedge clk);
    chk("busy7.hazard", 32'(id_hazard_o), 1);
    cyc;
    deliver(5'd7, 32'hDEAD);
    @(negedge clk);
    chk("deliver7.ready", 32'(mdu_ready_o), 1);
    port("deliver7", 0, 0, 0, 0);
    cyc;
    mdu_valid_i = 1'b0; ex_wen_i = 1'b1; ex_waddr_i = 5'd3; ex_wdata_i = 32'h55;
    @(negedge clk);
    port("drain7", 1, 7, 32'hDEAD, 1);
    chk("drain7.ready", 32'(mdu_ready_o), 0);
    chk("drain7.hazard", 32'(id_hazard_o), 1);
    cyc;
    @(negedge clk);
    port("conflict_ex3", 1, 3, 32'h55, 0);
    chk("after7.hazard", 32'(id_hazard_o), 0);
    chk("after7.ready", 32'(mdu_ready_o), 1);
    cyc;
    ex_wen_i = 1'b0; issue(5'd9);
    cyc;
    mdu_issue_i = 1'b0; ex_wen_i = 1'b1; ex_waddr_i = 5'd9; ex_wdata_i = 32'h99;
    @(negedge clk);
    port("waw.c1", 0, 0, 0, 1);
    cyc;
    @(negedge clk);
    port("waw.c2", 0, 0, 0, 1);
    cyc;
    deliver(5'd9, 32'h900);
    @(negedge clk);
    port("waw.deliver", 0, 0, 0, 1);
    cyc;
    mdu_valid_i = 1'b0;
    @(negedge clk);
    port("waw.drain", 1, 9, 32'h900, 1);
    cyc;
    @(negedge clk);
    port("waw.ex", 1, 9, 32'h99, 0);
    cyc;
    ex_wen_i = 1'b0; issue(5'd0); id_rs1_i = 5'd0; id_rs2_i = 5'd0;
    cyc;
    mdu_issue_i = 1'b0; ex_wen_i = 1'b1; ex_waddr_i = 5'd0; ex_wdata_i = 32'h77;
    @(negedge clk);
    port("x0.ex", 1, 0, 32'h77, 0);
    chk("x0.ready", 32'(mdu_ready_o), 1);
    cyc;
    ex_wen_i = 1'b0; issue(5'd4);
    cyc;
    mdu_issue_i = 1'b0; deliver(5'd4, 32'h44); id_rs2_i = 5'd4;
    @(negedge clk);
    chk("busy4.hazard", 32'(id_hazard_o), 1);
    cyc;
    mdu_valid_i = 1'b0; issue(5'd4);
    @(negedge clk);
    port("drain4", 1, 4, 32'h44, 0);
    cyc;
    mdu_issue_i = 1'b0;
    @(negedge clk);
    chk("setwins4.hazard", 32'(id_hazard_o), 1);
    port("setwins4.idle", 0, 0, 0, 0);
    cyc;
    deliver(5'd4, 32'h45);
    cyc;
    mdu_valid_i = 1'b0;
    @(negedge clk);
    port("drain4b", 1, 4, 32'h45, 0);
    cyc;
    @(negedge clk);
    chk("clear4.hazard", 32'(id_hazard_o), 0);
    cyc;
    issue(5'd12); id_rs1_i = 5'd12;
    cyc;
    mdu_issue_i = 1'b0; deliver(5'd12, 32'hC0DE);
    cyc;
    mdu_valid_i = 1'b0; rst = 1'b0;
    @(negedge clk);
    port("midrst", 0, 0, 0, 0);
    chk("midrst.hazard", 32'(id_hazard_o), 0);
    cyc;
    rst = 1'b1;
    @(negedge clk);
    port("midrst.after", 0, 0, 0, 0);
    chk("midrst.after.ready", 32'(mdu_ready_o), 1);
    chk("midrst.after.hazard", 32'(id_hazard_o), 0);
    cyc;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
